ram_master: RTL and testbench

Bus initiator that drives the synchronous single-port `ram` (16-bit data, 16-bit address, `cs`/`oe`/`we` strobes) on behalf of a CPU-side client. It accepts single- or multi-beat read/write requests over a valid/ready handshake and sequences the RAM strobes. Write data is taken from a stream port and read data is returned on a response port. It sits between the core's load/store or fetch logic and the `ram` instance, and is the only agent allowed to toggle the RAM strobes.

---
 rtl/ram_master_pkg.sv | 18 +
 rtl/ram_master.sv | 162 ++++++++++++++++
 tb/tb_ram_master.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_master_pkg.sv
// Shared types and sizing helpers for the ram_master bus initiator.
package ram_master_pkg;

  localparam int unsigned LEN_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRdIssue,
    StRdWait
  } state_e;

  // Width of a counter that spans 0 .. rd_lat-1, never narrower than one bit.
  function automatic int unsigned lat_w(input int unsigned rd_lat);
    return (rd_lat < 2) ? 1 : $clog2(rd_lat);
  endfunction

endpackage

// File: rtl/ram_master.sv
// Burst read/write initiator for the synchronous single-port ram: sequences cs/oe/we strobes,
// takes write beats from a stream port and returns read beats on a response port.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [DW-1:0]    wr_data,
  output logic             rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_last,
  output logic             done,
  output logic             ram_cs,
  output logic             ram_oe,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [DW-1:0]    ram_din,
  input  logic [DW-1:0]    ram_dout
);

  localparam int unsigned   LatW    = lat_w(RD_LAT);
  localparam logic [LatW-1:0] LatLast = LatW'(RD_LAT - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [LatW-1:0]  lat_q, lat_d;
  logic             wr_pend_q, wr_pend_d;

  logic             ram_cs_d, ram_oe_d, ram_we_d;
  logic [AW-1:0]    ram_addr_d;
  logic [DW-1:0]    ram_din_d;
  logic             rsp_valid_d, rsp_last_d, done_d;
  logic [DW-1:0]    rsp_data_d;

  logic accept, wr_beat, rd_sample, last_beat;

  assign req_ready = (state_q == StIdle);
  assign wr_ready  = (state_q == StWr);
  assign accept    = req_valid & req_ready;
  assign wr_beat   = wr_valid & wr_ready;
  assign rd_sample = (state_q == StRdWait) && (lat_q == LatLast);
  assign last_beat = (beat_q == len_q);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = req_we ? StWr : StRdIssue;
      StWr:      if (wr_beat && last_beat) state_d = StIdle;
      StRdIssue: state_d = StRdWait;
      StRdWait:  if (rd_sample) state_d = last_beat ? StIdle : StRdIssue;
      default:   state_d = StIdle;
    endcase
  end

  // Address, beat and latency counters
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    beat_d = beat_q;
    lat_d  = (state_q == StRdWait) ? lat_q + 1'b1 : '0;
    if (accept) begin
      addr_d = req_addr;
      len_d  = req_len;
      beat_d = '0;
    end
    if (wr_beat || (rd_sample && !last_beat)) begin
      addr_d = addr_q + 1'b1;
      beat_d = beat_q + 1'b1;
    end
  end

  // Output logic: next values of the registered strobes and response
  always_comb begin
    ram_cs_d    = 1'b0;
    ram_oe_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr;
    ram_din_d   = ram_din;
    rsp_valid_d = 1'b0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data;
    wr_pend_d   = 1'b0;
    done_d      = wr_pend_q;
    // Issue is registered on entry so the strobe lands in the RD_ISSUE cycle itself.
    if (state_d == StRdIssue) begin
      ram_cs_d   = 1'b1;
      ram_oe_d   = 1'b1;
      ram_addr_d = addr_d;
    end
    if (wr_beat) begin
      ram_cs_d   = 1'b1;
      ram_we_d   = 1'b1;
      ram_addr_d = addr_q;
      ram_din_d  = wr_data;
      wr_pend_d  = last_beat;
    end
    if (rd_sample) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = ram_dout;
      rsp_last_d  = last_beat;
      done_d      = last_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      wr_pend_q <= 1'b0;
      ram_cs    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      done      <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      wr_pend_q <= wr_pend_d;
      ram_cs    <= ram_cs_d;
      ram_oe    <= ram_oe_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_din   <= ram_din_d;
      rsp_valid <= rsp_valid_d;
      rsp_last  <= rsp_last_d;
      rsp_data  <= rsp_data_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: directed vector table, reset-mid-burst sequence and
// randomized back-to-back bursts checked against a word-array memory model.
module tb_ram_master;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [2:0]  req_len;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rsp_valid, rsp_last, done;
  logic [15:0] rsp_data;
  logic        ram_cs, ram_oe, ram_we;
  logic [15:0] ram_addr, ram_din, ram_dout;
  logic        preload;

  ram_master #(.AW(16), .DW(16), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .done      (done),
    .ram_cs    (ram_cs),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a == 16'd7) ? 16'h1234 : (16'(a * 16'h9E37) ^ 16'h5A5A);
  endfunction

  // Synchronous single-port ram, one cycle read latency.
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
    end else begin
      if (ram_cs && ram_we) mem[ram_addr] <= ram_din;
      if (ram_cs && ram_oe) ram_dout <= mem[ram_addr];
    end
  end

  int inv_err = 0;
  always @(posedge clk) if (ram_we && ram_oe) inv_err++;

  logic [15:0] model [0:65535];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One burst, starting in the current cycle (cycle 0). Returns with the done cycle current.
  task automatic run_txn(input bit we, input logic [15:0] addr, input logic [2:0] len,
                         input logic [15:0] wbase, input int gap_after, input int gap_len,
                         input int pct, input bit noise, input int exp_done);
    int n, t, sent, nwr, nrd, nrsp, done_t, last_str, gap_left;
    int acc_t [8];
    logic [15:0] wd [8];
    logic [15:0] a;
    n = int'(len) + 1;
    for (int i = 0; i < 8; i++) acc_t[i] = -10;
    chk("req_ready before request", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len;
    step();
    req_valid = 1'b0;
    t = 1; sent = 0; nwr = 0; nrd = 0; nrsp = 0; done_t = -1; last_str = -1;
    gap_left = gap_len;
    while (done_t < 0 && t < 100) begin
      wr_valid = 1'b0;
      wr_data  = 16'($urandom);
      if (we && sent < n) begin
        if (sent == gap_after && gap_left > 0) gap_left--;
        else if ($urandom_range(99) < pct) begin
          wr_valid = 1'b1;
          wr_data  = wbase + 16'(sent);
        end
      end
      // Requests while busy must be ignored.
      req_valid = noise && (we ? (sent < n) : !done) && ($urandom_range(1) == 1);
      req_we = $urandom_range(1) == 1; req_addr = 16'($urandom); req_len = 3'($urandom);
      if (ram_cs && ram_we) begin
        if (we && nwr < n) begin
          a = addr + 16'(nwr);
          chk("wr strobe addr", {16'd0, ram_addr}, {16'd0, a});
          chk("wr strobe data", {16'd0, ram_din}, {16'd0, wd[nwr]});
          chk("wr strobe cycle", t, acc_t[nwr] + 1);
        end
        nwr++;
        last_str = t;
      end
      if (ram_cs && ram_oe) begin
        if (!we && nrd < n) begin
          a = addr + 16'(nrd);
          chk("rd strobe addr", {16'd0, ram_addr}, {16'd0, a});
          chk("rd strobe cycle", t, 1 + nrd * (RD_LAT + 1));
        end
        nrd++;
      end
      if (rsp_valid) begin
        if (!we && nrsp < n) begin
          a = addr + 16'(nrsp);
          chk("rsp data", {16'd0, rsp_data}, {16'd0, model[a]});
          chk("rsp last", {31'd0, rsp_last}, {31'd0, nrsp == n - 1});
          chk("rsp cycle", t, (RD_LAT + 1) * (nrsp + 1) + 1);
        end
        nrsp++;
      end
      if (done) done_t = t;
      if (wr_valid && wr_ready) begin
        acc_t[sent] = t;
        wd[sent] = wr_data;
        a = addr + 16'(sent);
        model[a] = wr_data;
        sent++;
      end
      if (done_t < 0) begin
        step();
        t++;
      end
    end
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    chk("done seen", {31'd0, done_t >= 0}, 32'd1);
    if (we) begin
      chk("write strobe count", nwr, n);
      chk("read strobes in write", nrd, 0);
      chk("rsp in write", nrsp, 0);
      chk("write done after last strobe", done_t, last_str + 1);
    end else begin
      chk("read strobe count", nrd, n);
      chk("rsp count", nrsp, n);
      chk("write strobes in read", nwr, 0);
      chk("read done with last rsp", done_t, (RD_LAT + 1) * n + 1);
    end
    if (exp_done > 0) chk("done cycle", done_t, exp_done);
    chk("req_ready in done cycle", {31'd0, req_ready}, 32'd1);
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [2:0]  len;
    logic [15:0] wbase;
    int          gap_after;
    int          gap_len;
    int          exp_done;
  } vec_t;

  vec_t vecs [6];
  int   cnt;

  initial begin
    vecs[0] = '{1'b0, 16'h0007, 3'd0, 16'h0000, -1, 0, 3};
    vecs[1] = '{1'b0, 16'h0007, 3'd5, 16'h0000, -1, 0, 13};
    vecs[2] = '{1'b1, 16'h0005, 3'd0, 16'hDEAD, -1, 0, 3};
    vecs[3] = '{1'b0, 16'h0005, 3'd0, 16'h0000, -1, 0, 3};
    vecs[4] = '{1'b1, 16'hFFFE, 3'd3, 16'h00A0, 2, 2, 8};
    vecs[5] = '{1'b0, 16'hFFFE, 3'd3, 16'h0000, -1, 0, 9};

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
    wr_valid = 1'b0; wr_data = '0;
    for (int i = 0; i < 65536; i++) model[i] = pat(16'(i));
    rst = 1'b1; preload = 1'b1;
    step();
    preload = 1'b0;
    step();
    step();
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_last", {31'd0, rsp_last}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset strobes", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
    chk("reset ram_addr", {16'd0, ram_addr}, 32'd0);
    chk("reset ram_din", {16'd0, ram_din}, 32'd0);
    chk("reset rsp_data", {16'd0, rsp_data}, 32'd0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      run_txn(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].wbase, vecs[v].gap_after,
              vecs[v].gap_len, 100, 1'b0, vecs[v].exp_done);
    end
    chk("mem[5] after write", {16'd0, mem[5]}, 32'h0000DEAD);
    chk("mem[0] after wrap write", {16'd0, mem[0]}, 32'h000000A2);

    // Reset during the third beat's RD_WAIT of an 8-beat read.
    step();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0100; req_len = 3'd7;
    step();
    req_valid = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      if (rsp_valid) cnt++;
      if (c < 6) step();
    end
    chk("rsp before reset", cnt, 2);
    rst = 1'b1;
    step();
    chk("strobes after reset", {29'd0, ram_cs, ram_oe, ram_we}, 32'd0);
    chk("rsp_valid after reset", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready after reset", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (rsp_valid || done || ram_cs) cnt++;
      step();
    end
    chk("activity after abandoned burst", cnt, 0);
    run_txn(1'b0, 16'h0007, 3'd1, 16'h0000, -1, 0, 100, 1'b0, 5);

    // Randomized back-to-back bursts, new request issued in each done cycle.
    for (int r = 0; r < 40; r++) begin
      logic [15:0] ra;
      ra = ($urandom_range(3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(4)))
                                    : 16'($urandom_range(63));
      run_txn($urandom_range(1) == 1, ra, 3'($urandom), 16'($urandom), -1, 0,
              $urandom_range(100, 50), 1'b1, 0);
    end

    chk("we/oe overlap cycles", inv_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule
